// File: rtl/bmc_cpld_pkg.sv
// Shared definitions for the BMC CPLD reset-conditioning logic.
// Holds the conditioner FSM state encodings (one-hot), the default
// clock rate in kHz (clock cycles per millisecond) and a saturating
// 8-bit increment helper used by event counters.
package bmc_cpld_pkg;

  localparam int unsigned CLK_FREQ_KHZ_DEF = 25000;

  // One-hot FSM encodings. Bit 2 is the S_DEASSERT flop, which drives
  // the conditioned reset output directly.
  localparam int unsigned ST_W           = 3;
  localparam logic [2:0]  S_ASSERT       = 3'b001;
  localparam logic [2:0]  S_ARMED        = 3'b010;
  localparam logic [2:0]  S_DEASSERT     = 3'b100;
  localparam int unsigned S_DEASSERT_BIT = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond tick generator.
// Ports:
//   clock       - system clock
//   reset       - asynchronous, active-low reset
//   int_1ms_en  - one-cycle pulse every CLK_FREQ_KHZ cycles; the first
//                 pulse is in the CLK_FREQ_KHZ-th cycle after reset release
module ms_tick_gen
  import bmc_cpld_pkg::*;
#(
  parameter int unsigned CLK_FREQ_KHZ = CLK_FREQ_KHZ_DEF
) (
  input  logic clock,
  input  logic reset,
  output logic int_1ms_en
);

  localparam int unsigned      DIV_W    = (CLK_FREQ_KHZ > 1) ? $clog2(CLK_FREQ_KHZ) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FREQ_KHZ - 1);

  logic [DIV_W-1:0] r_div;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Decoded straight from the divider register so the pulse lands in the
  // same cycle the divider shows its terminal value.
  assign int_1ms_en = (r_div == DIV_LAST);

endmodule

// File: rtl/rc_perst_conditioner.sv
// PERST# conditioner for the SG2042 root-complex reset feeding the BMC
// PCIe reset stage. Synchronizes and de-glitches the raw PERST#, then
// enforces a minimum reset-low time before releasing the conditioned
// reset.
// Ports:
//   clock        - system clock
//   reset        - asynchronous, active-low reset
//   perst_raw_n  - raw PERST# (asynchronous, low = reset)
//   rc_pcie_rst  - conditioned PERST# (low = reset), straight from a flop
//   int_1ms_en   - 1 ms tick pulse, shared with other reset timers
//   perst_glitch - one-cycle pulse when a level change is rejected
//   perst_cnt    - accepted PERST# assertions, saturating at 255
module rc_perst_conditioner
  import bmc_cpld_pkg::*;
#(
  parameter int unsigned CLK_FREQ_KHZ  = CLK_FREQ_KHZ_DEF,
  parameter int unsigned GLITCH_CYCLES = 16,
  parameter int unsigned MIN_LOW_MS    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       perst_raw_n,
  output logic       rc_pcie_rst,
  output logic       int_1ms_en,
  output logic       perst_glitch,
  output logic [7:0] perst_cnt
);

  localparam int unsigned      FCNT_W    = $clog2(GLITCH_CYCLES + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(GLITCH_CYCLES - 1);
  localparam logic [7:0]        MS_LAST   = 8'(MIN_LOW_MS);

  logic              w_tick;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_filt;
  logic [FCNT_W-1:0] r_fcnt;
  logic              r_glitch;
  logic [ST_W-1:0]   r_state;
  logic [ST_W-1:0]   w_state_nxt;
  logic [7:0]        r_ms_cnt;
  logic [7:0]        w_ms_nxt;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nxt;

  ms_tick_gen #(
    .CLK_FREQ_KHZ(CLK_FREQ_KHZ)
  ) u_tick (
    .clock      (clock),
    .reset      (reset),
    .int_1ms_en (w_tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= perst_raw_n;
      r_sync2 <= r_sync1;
    end
  end

  // Glitch filter. The acceptance branch is tested first, so a cycle that
  // completes the stable run can never also flag a glitch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_filt   <= 1'b0;
      r_fcnt   <= '0;
      r_glitch <= 1'b0;
    end else begin
      r_glitch <= 1'b0;
      if (r_sync2 != r_filt) begin
        if (r_fcnt == FCNT_LAST) begin
          r_filt <= r_sync2;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + FCNT_W'(1);
        end
      end else if (r_fcnt != '0) begin
        r_fcnt   <= '0;
        r_glitch <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ms_nxt    = r_ms_cnt;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_ASSERT: begin
        // Tick that brings ms_cnt to MIN_LOW_MS+1 ends the low window;
        // entry mid-interval means at least MIN_LOW_MS whole ms elapse.
        if (w_tick) begin
          w_ms_nxt = r_ms_cnt + 8'd1;
          if (r_ms_cnt == MS_LAST) begin
            w_state_nxt = r_filt ? S_DEASSERT : S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (r_filt) begin
          w_state_nxt = S_DEASSERT;
        end
      end
      S_DEASSERT: begin
        // Clearing ms_cnt here also discards a tick landing on entry.
        if (!r_filt) begin
          w_state_nxt = S_ASSERT;
          w_ms_nxt    = '0;
          w_cnt_nxt   = sat_inc8(r_cnt);
        end
      end
      default: begin
        w_state_nxt = S_ASSERT;
        w_ms_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_ASSERT;
      r_ms_cnt <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ms_cnt <= w_ms_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign rc_pcie_rst  = r_state[S_DEASSERT_BIT];
  assign int_1ms_en   = w_tick;
  assign perst_glitch = r_glitch;
  assign perst_cnt    = r_cnt;

endmodule

// File: tb/tb_rc_perst_conditioner.sv
// Self-checking bench for rc_perst_conditioner (CLK_FREQ_KHZ=10,
// GLITCH_CYCLES=4, MIN_LOW_MS=2). A behavioural model predicts output
// events (reset edges, glitch pulses, ticks) into queues; a monitor pops
// and compares them as the DUT presents each event.
module tb_rc_perst_conditioner;

  localparam int C   = 10;
  localparam int G   = 4;
  localparam int MIN = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       perst_raw_n = 1'b1;
  logic       rc_pcie_rst;
  logic       int_1ms_en;
  logic       perst_glitch;
  logic [7:0] perst_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    bit lvl;
    int cnt;
  } ev_t;

  ev_t q_rc[$];
  int  q_gl[$];
  int  q_tk[$];

  always #5 clock = ~clock;

  rc_perst_conditioner #(
    .CLK_FREQ_KHZ (C),
    .GLITCH_CYCLES(G),
    .MIN_LOW_MS   (MIN)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .perst_raw_n (perst_raw_n),
    .rc_pcie_rst (rc_pcie_rst),
    .int_1ms_en  (int_1ms_en),
    .perst_glitch(perst_glitch),
    .perst_cnt   (perst_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Cycle n = n-th rising edge after reset release. Synchronized PERST#
  // is raw input delayed two edges. Filtered level flips once the last G
  // synchronized samples all disagree with it. The low window ends one
  // edge after the (MIN+1)-th tick at or after the entry edge.
  int m_n;
  bit m_rawp;
  bit m_filt;
  bit m_rel;
  bit m_rc;
  int m_exp_at;
  int m_cnt;
  bit sh[$];
  bit m_fp;
  bit m_nf;
  bit m_gl;
  bit m_alld;

  function automatic int expiry(input int e);
    return e + (C - 1 - (e % C)) + MIN * C + 1;
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_n = 0; m_rawp = 0; m_filt = 0; m_rel = 0; m_rc = 0; m_cnt = 0;
      m_exp_at = expiry(0);
      sh.delete();
      for (int k = 0; k <= G; k++) sh.push_back(1'b0);
      q_rc.delete(); q_gl.delete(); q_tk.delete();
    end else begin
      m_n++;
      m_fp = m_filt;
      m_alld = 1'b1;
      for (int k = 0; k < G; k++) if (sh[sh.size() - 1 - k] == m_fp) m_alld = 1'b0;
      m_nf = m_alld ? !m_fp : m_fp;
      m_gl = (sh[sh.size() - 1] == m_fp) && (sh[sh.size() - 2] != m_fp);
      if (m_rel) begin
        if (!m_fp) begin
          m_rel = 1'b0;
          if (m_cnt < 255) m_cnt++;
          m_exp_at = expiry(m_n);
        end
      end else if (m_n >= m_exp_at && m_fp) begin
        m_rel = 1'b1;
      end
      sh.push_back(m_rawp);
      if (sh.size() > G + 1) void'(sh.pop_front());
      m_rawp = perst_raw_n;
      m_filt = m_nf;
      if (m_rel != m_rc) begin
        q_rc.push_back('{m_n, m_rel, m_cnt});
        m_rc = m_rel;
      end
      if (m_gl) q_gl.push_back(m_n);
      if (m_n % C == C - 1) q_tk.push_back(m_n);
    end
  end

  // ---------------- monitor ----------------
  int  mon_n;
  bit  mon_prc;
  ev_t mon_ev;
  int  mon_c;

  always @(negedge clock) begin
    if (!reset) begin
      mon_n = 0;
      mon_prc = 0;
    end else begin
      mon_n++;
      while (q_rc.size() > 0 && q_rc[0].cyc < mon_n) begin
        mon_ev = q_rc.pop_front();
        chk("rc_edge_missing", 32'(mon_n), mon_ev.cyc);
      end
      while (q_gl.size() > 0 && q_gl[0] < mon_n) begin
        mon_c = q_gl.pop_front();
        chk("glitch_missing", 32'(mon_n), mon_c);
      end
      while (q_tk.size() > 0 && q_tk[0] < mon_n) begin
        mon_c = q_tk.pop_front();
        chk("tick_missing", 32'(mon_n), mon_c);
      end
      if (rc_pcie_rst !== mon_prc) begin
        if (q_rc.size() == 0) begin
          chk("rc_edge_unexpected", 32'(rc_pcie_rst), int'(mon_prc));
        end else begin
          mon_ev = q_rc.pop_front();
          chk("rc_edge_cycle", 32'(mon_n), mon_ev.cyc);
          chk("rc_level", 32'(rc_pcie_rst), int'(mon_ev.lvl));
          chk("perst_cnt_at_edge", 32'(perst_cnt), mon_ev.cnt);
        end
        mon_prc = rc_pcie_rst;
      end
      if (perst_glitch !== 1'b0) begin
        if (q_gl.size() == 0) chk("glitch_unexpected", 32'(perst_glitch), 0);
        else chk("glitch_cycle", 32'(mon_n), q_gl.pop_front());
      end
      if (int_1ms_en !== 1'b0) begin
        if (q_tk.size() == 0) chk("tick_unexpected", 32'(int_1ms_en), 0);
        else chk("tick_cycle", 32'(mon_n), q_tk.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input bit v, input int n);
    perst_raw_n = v;
    repeat (n) @(negedge clock);
  endtask

  int waited;

  initial begin
    reset = 1'b0;
    perst_raw_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_rc", 32'(rc_pcie_rst), 0);
    chk("reset_tick", 32'(int_1ms_en), 0);
    chk("reset_glitch", 32'(perst_glitch), 0);
    chk("reset_cnt", 32'(perst_cnt), 0);
    #2 reset = 1'b1;

    hold(1'b1, 40);
    chk("rc_up_after_min", 32'(rc_pcie_rst), 1);
    chk("cnt_after_boot", 32'(perst_cnt), 0);

    hold(1'b0, 3);
    hold(1'b1, 12);
    chk("rc_high_after_glitch", 32'(rc_pcie_rst), 1);

    hold(1'b0, 5);
    hold(1'b1, 60);
    chk("cnt_after_first_assert", 32'(perst_cnt), 1);

    hold(1'b0, 100);
    hold(1'b1, 20);
    chk("cnt_after_long_assert", 32'(perst_cnt), 2);
    chk("rc_after_armed", 32'(rc_pcie_rst), 1);

    repeat (150) hold(bit'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
    hold(1'b1, 60);

    repeat (260) begin
      hold(1'b0, 6);
      hold(1'b1, 45);
    end
    chk("cnt_saturated", 32'(perst_cnt), 255);

    waited = 0;
    while (rc_pcie_rst !== 1'b1 && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    chk("rc_high_before_reset", 32'(rc_pcie_rst), 1);
    #2 reset = 1'b0;
    #1 chk("rc_async_reset", 32'(rc_pcie_rst), 0);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    chk("cnt_after_reset", 32'(perst_cnt), 0);
    chk("rc_after_reset", 32'(rc_pcie_rst), 0);
    hold(1'b1, 40);
    chk("rc_up_after_reset", 32'(rc_pcie_rst), 1);

    hold(1'b1, 3);
    chk("q_rc_drained", 32'(q_rc.size()), 0);
    chk("q_glitch_drained", 32'(q_gl.size()), 0);
    chk("q_tick_drained", 32'(q_tk.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
